// File: rtl/tlul_data_mem_pkg.sv
// Types and helpers for the TL-UL data memory: response FIFO entry and byte-lane decode.
package tlul_data_mem_pkg;

    localparam int DataW = 32;
    localparam int MaskW = 4;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [1:0]       size;
        logic [7:0]       source;
        logic             error;
        logic [DataW-1:0] data;
    } rsp_entry_t;

    // Unsupported sizes fall back to a full lane; they are rejected as errors anyway.
    function automatic logic [MaskW-1:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [MaskW-1:0] lane;
        case (size)
            2'd0:    lane = 4'b0001 << addr_lo;
            2'd1:    lane = 4'b0011 << {addr_lo[1], 1'b0};
            default: lane = 4'b1111;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Shared TileLink-UL channel types and opcodes used by devices behind the crossbar.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_data_mem_if.sv
// TL-UL device port bundle: host-to-device A channel plus d_ready, device-to-host D channel plus a_ready.
interface tlul_data_mem_if;

    tlul_pkg::tl_h2d_t tl_d_i;
    tlul_pkg::tl_d2h_t tl_d_o;

    modport master (output tl_d_i, input tl_d_o);
    modport slave  (input tl_d_i, output tl_d_o);

endinterface

// File: rtl/tlul_data_mem_rsp_fifo.sv
// Circular response FIFO; pointers wrap modulo Outstanding so any depth >= 2 works.
module tlul_data_mem_rsp_fifo #(
    parameter int  Outstanding = 4,
    parameter type entry_t     = logic [31:0],
    localparam int PtrW        = (Outstanding > 1) ? $clog2(Outstanding) : 1,
    localparam int CntW        = $clog2(Outstanding + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  entry_t          push_data,
    input  logic            pop,
    output entry_t          head,
    output logic [CntW-1:0] count
);

    entry_t          storage [Outstanding];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CntW'(Outstanding));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Outstanding - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            if (do_push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) storage[wptr] <= push_data;
    end

    assign head = storage[rptr];

endmodule

// File: rtl/tlul_data_mem.sv
// TL-UL data memory with byte writes, error checking and a response FIFO for D-channel backpressure.
// Optional per-byte even parity store enabled by defining DATA_MEM_PARITY_EN.
module tlul_data_mem
    import tlul_pkg::*;
    import tlul_data_mem_pkg::*;
#(
    parameter int          Depth       = 1024,
    parameter int          Outstanding = 4,
    parameter logic [31:0] BaseAddr    = 32'h1000_0000
) (
    input logic             clock,
    input logic             reset,
    tlul_data_mem_if.slave  tl
);

    localparam int AW   = $clog2(Depth);
    localparam int CntW = $clog2(Outstanding + 1);

    tl_h2d_t req;
    tl_d2h_t rsp;

    assign req       = tl.tl_d_i;
    assign tl.tl_d_o = rsp;

    logic [CntW-1:0]  fifo_count;
    logic             s1_valid;
    logic             a_ready;
    logic             accept;
    logic             d_valid;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;

    logic [AW-1:0]    idx;
    logic [MaskW-1:0] lane;
    logic             is_get;
    logic             is_put_full;
    logic             is_put_partial;
    logic             req_err;
    logic             write_en;

    assign a_ready = reset && ((int'(fifo_count) + int'(s1_valid)) < Outstanding);
    assign accept  = req.a_valid && a_ready;

    assign idx            = req.a_address[AW+1:2];
    assign lane           = lane_mask(req.a_size, req.a_address[1:0]);
    assign is_get         = (req.a_opcode == Get);
    assign is_put_full    = (req.a_opcode == PutFullData);
    assign is_put_partial = (req.a_opcode == PutPartialData);

    always_comb begin
        req_err = 1'b0;
        if (!(is_get || is_put_full || is_put_partial))                        req_err = 1'b1;
        if (req.a_size == 2'd3)                                                req_err = 1'b1;
        if (req.a_size == 2'd1 && req.a_address[0])                            req_err = 1'b1;
        if (req.a_size == 2'd2 && req.a_address[1:0] != 2'b00)                 req_err = 1'b1;
        if (req.a_address[31:AW+2] != BaseAddr[31:AW+2])                       req_err = 1'b1;
        if (is_put_full && req.a_mask != lane)                                 req_err = 1'b1;
        if (is_put_partial && (((req.a_mask & ~lane) != '0) || req.a_mask == '0)) req_err = 1'b1;
    end

    assign write_en = accept && !req_err && (is_put_full || is_put_partial);

    // RAM contents survive reset; only the pipeline and FIFO are cleared.
    logic [MaskW-1:0][7:0] mem [Depth];
    logic [DataW-1:0]      rdata;

    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int b = 0; b < MaskW; b++) begin
                if (req.a_mask[b]) mem[idx][b] <= req.a_data[8*b +: 8];
            end
        end
        if (accept) rdata <= mem[idx];
    end

    logic par_err;

`ifdef DATA_MEM_PARITY_EN
    logic [MaskW-1:0] mem_par [Depth];
    logic [MaskW-1:0] rpar;
    logic [MaskW-1:0] rdata_par;

    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int b = 0; b < MaskW; b++) begin
                if (req.a_mask[b]) mem_par[idx][b] <= ^req.a_data[8*b +: 8];
            end
        end
        if (accept) rpar <= mem_par[idx];
    end

    always_comb begin
        rdata_par = '0;
        for (int b = 0; b < MaskW; b++) begin
            rdata_par[b] = ^rdata[8*b +: 8];
        end
        par_err = |(rdata_par ^ rpar);
    end
`else
    assign par_err = 1'b0;
`endif

    logic       s1_get;
    logic [1:0] s1_size;
    logic [7:0] s1_source;
    logic       s1_error;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_get    <= 1'b0;
            s1_size   <= '0;
            s1_source <= '0;
            s1_error  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_get    <= is_get;
                s1_size   <= req.a_size;
                s1_source <= req.a_source;
                s1_error  <= req_err;
            end
        end
    end

    // Parity faults still return the stored word so software can inspect it.
    always_comb begin
        push_entry        = '0;
        push_entry.opcode = s1_get ? AccessAckData : AccessAck;
        push_entry.size   = s1_size;
        push_entry.source = s1_source;
        push_entry.error  = s1_error || (s1_get && par_err);
        push_entry.data   = (s1_get && !s1_error) ? rdata : '0;
    end

    tlul_data_mem_rsp_fifo #(
        .Outstanding (Outstanding),
        .entry_t     (rsp_entry_t)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (d_valid && req.d_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign d_valid = reset && (fifo_count != '0);

    always_comb begin
        rsp         = '0;
        rsp.a_ready = a_ready;
        rsp.d_valid = d_valid;
        if (d_valid) begin
            rsp.d_opcode = head.opcode;
            rsp.d_size   = head.size;
            rsp.d_source = head.source;
            rsp.d_error  = head.error;
            rsp.d_data   = head.data;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{req.a_param, req.a_user};

endmodule

// File: tb/tb_tlul_data_mem.sv
// Scoreboard bench for tlul_data_mem: an in-order reference model queues expected D responses.
module tb_tlul_data_mem;
    import tlul_pkg::*;
    import tlul_data_mem_pkg::*;

    localparam int          Depth       = 1024;
    localparam int          Outstanding = 4;
    localparam logic [31:0] BaseAddr    = 32'h1000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    tlul_data_mem_if io();

    tlul_data_mem #(
        .Depth       (Depth),
        .Outstanding (Outstanding),
        .BaseAddr    (BaseAddr)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tl    (io)
    );

    always #5 clock = ~clock;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          rsp_seen     = 0;
    rsp_entry_t  exp_q [$];
    logic [31:0] model [int];
    rsp_entry_t  mon_got;
    rsp_entry_t  mon_exp;

    always @(negedge clock) begin
        if (reset && io.tl_d_o.d_valid && io.tl_d_i.d_ready) begin
            rsp_seen++;
            tests_run++;
            mon_got = '{opcode: io.tl_d_o.d_opcode, size: io.tl_d_o.d_size, source: io.tl_d_o.d_source,
                        error: io.tl_d_o.d_error, data: io.tl_d_o.d_data};
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_rsp: got src=%0d data=%08h, required no response",
                         mon_got.source, mon_got.data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp || io.tl_d_o.d_param !== 3'd0 || io.tl_d_o.d_sink !== 1'b0
                    || io.tl_d_o.d_user !== 16'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL rsp_check: got op=%0d size=%0d src=%0d err=%0d data=%08h param=%0d sink=%0d user=%0h, required op=%0d size=%0d src=%0d err=%0d data=%08h param=0 sink=0 user=0",
                             mon_got.opcode, mon_got.size, mon_got.source, mon_got.error, mon_got.data,
                             io.tl_d_o.d_param, io.tl_d_o.d_sink, io.tl_d_o.d_user,
                             mon_exp.opcode, mon_exp.size, mon_exp.source, mon_exp.error, mon_exp.data);
                end
            end
        end
    end

    // Reference model: decides the response and applies writes in acceptance order.
    function automatic rsp_entry_t model_req(input logic [2:0] op, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [3:0] mask,
                                             input logic [31:0] data, input logic [7:0] src);
        rsp_entry_t  r;
        logic [3:0]  lane;
        logic        err;
        logic [31:0] cur;
        int          w;
        w = int'(addr[11:2]);
        case (size)
            2'd0:    lane = 4'b0001 << addr[1:0];
            2'd1:    lane = addr[1] ? 4'b1100 : 4'b0011;
            default: lane = 4'b1111;
        endcase
        err = 1'b0;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4))          err = 1'b1;
        if (size == 2'd3)                                       err = 1'b1;
        if (size == 2'd1 && addr[0])                            err = 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'b00)                 err = 1'b1;
        if (addr[31:12] != BaseAddr[31:12])                     err = 1'b1;
        if (op == 3'd0 && mask != lane)                         err = 1'b1;
        if (op == 3'd1 && (((mask & ~lane) != 4'd0) || mask == 4'd0)) err = 1'b1;
        r.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
        r.size   = size;
        r.source = src;
        r.error  = err;
        r.data   = 32'd0;
        if (!err) begin
            cur = model.exists(w) ? model[w] : 32'd0;
            if (op == 3'd4) begin
                r.data = cur;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
                end
                model[w] = cur;
            end
        end
        return r;
    endfunction

    task automatic set_req(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        io.tl_d_i.a_valid   = 1'b1;
        io.tl_d_i.a_opcode  = op;
        io.tl_d_i.a_size    = size;
        io.tl_d_i.a_address = addr;
        io.tl_d_i.a_mask    = mask;
        io.tl_d_i.a_data    = data;
        io.tl_d_i.a_source  = src;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                        output int waited);
        int n;
        n = 0;
        set_req(op, size, addr, mask, data, src);
        @(negedge clock);
        while (!io.tl_d_o.a_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        waited = n;
        if (!io.tl_d_o.a_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got a_ready=0 after %0d cycles, required acceptance", n);
            @(posedge clock); #1;
            io.tl_d_i.a_valid = 1'b0;
            return;
        end
        exp_q.push_back(model_req(op, size, addr, mask, data, src));
        @(posedge clock); #1;
        io.tl_d_i.a_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_%s: got %0d responses outstanding, required 0", name, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        io.tl_d_i = '0;
        io.tl_d_i.d_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.a_ready !== 1'b0 || io.tl_d_o.d_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake: got a_ready=%0b d_valid=%0b, required 0 0",
                     io.tl_d_o.a_ready, io.tl_d_o.d_valid);
        end
        tests_run++;
        if (io.tl_d_o.d_error !== 1'b0 || io.tl_d_o.d_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fields: got d_error=%0b d_data=%08h, required 0 00000000",
                     io.tl_d_o.d_error, io.tl_d_o.d_data);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.a_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got a_ready=%0b, required 1", io.tl_d_o.a_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        int w;
        send(PutFullData, 2'd2, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 8'd1, w);
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.d_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL latency_early: got d_valid=%0b one cycle after accept, required 0", io.tl_d_o.d_valid);
        end
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.d_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL latency_n2: got d_valid=%0b two cycles after accept, required 1", io.tl_d_o.d_valid);
        end
        @(posedge clock); #1;
        wait_drain("put");
        send(Get, 2'd2, 32'h1000_0010, 4'hF, 32'd0, 8'd2, w);
        wait_drain("get");
    endtask

    task automatic test_partial();
        int w;
        send(PutFullData,    2'd2, 32'h1000_0010, 4'hF,    32'h1122_3344, 8'd3, w);
        send(PutPartialData, 2'd0, 32'h1000_0012, 4'b0100, 32'h00AA_0000, 8'd4, w);
        send(Get,            2'd2, 32'h1000_0010, 4'h0,    32'd0,         8'd5, w);
        send(PutFullData,    2'd2, 32'h1000_0014, 4'hF,    32'hCAFE_F00D, 8'd6, w);
        send(PutPartialData, 2'd1, 32'h1000_0016, 4'b1100, 32'h1234_0000, 8'd7, w);
        send(Get,            2'd1, 32'h1000_0014, 4'b0011, 32'd0,         8'd8, w);
        wait_drain("partial");
    endtask

    task automatic test_errors();
        int w;
        send(Get,            2'd2, 32'h2000_0000, 4'hF,    32'd0,         8'd40, w);
        send(PutFullData,    2'd2, 32'h1000_0010, 4'b0111, 32'hFFFF_FFFF, 8'd41, w);
        send(PutFullData,    2'd1, 32'h1000_0011, 4'b0011, 32'hFFFF_FFFF, 8'd42, w);
        send(3'd2,           2'd2, 32'h1000_0010, 4'hF,    32'hFFFF_FFFF, 8'd43, w);
        send(Get,            2'd3, 32'h1000_0010, 4'hF,    32'd0,         8'd44, w);
        send(PutPartialData, 2'd0, 32'h1000_0010, 4'b0010, 32'hFFFF_FFFF, 8'd45, w);
        send(PutPartialData, 2'd0, 32'h1000_0010, 4'b0000, 32'hFFFF_FFFF, 8'd46, w);
        send(Get,            2'd2, 32'h1000_0012, 4'hF,    32'd0,         8'd47, w);
        send(Get,            2'd2, 32'h1000_0010, 4'hF,    32'd0,         8'd48, w);
        wait_drain("errors");
    endtask

    task automatic test_back_to_back();
        int          w;
        int          total_wait;
        int          word;
        int          lo;
        logic [31:0] addr;
        total_wait = 0;
        for (int i = 0; i < 8; i++) begin
            send(PutFullData, 2'd2, BaseAddr + 32'(4 * i), 4'hF, $urandom, 8'(60 + i), w);
            total_wait += w;
        end
        for (int i = 0; i < 24; i++) begin
            word = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
                0: begin
                    addr = BaseAddr + 32'(4 * word);
                    send(Get, 2'd2, addr, 4'hF, 32'd0, 8'(100 + i), w);
                end
                1: begin
                    lo   = $urandom_range(0, 3);
                    addr = BaseAddr + 32'(4 * word + lo);
                    send(PutPartialData, 2'd0, addr, 4'b0001 << lo, $urandom, 8'(100 + i), w);
                end
                default: begin
                    lo   = 2 * $urandom_range(0, 1);
                    addr = BaseAddr + 32'(4 * word + lo);
                    send(PutPartialData, 2'd1, addr, 4'b0011 << lo, $urandom, 8'(100 + i), w);
                end
            endcase
            total_wait += w;
        end
        tests_run++;
        if (total_wait != 0) begin
            tests_failed++;
            $display("[TB] FAIL throughput: got %0d stall cycles over 32 requests, required 0", total_wait);
        end
        for (int i = 0; i < 8; i++) begin
            send(Get, 2'd2, BaseAddr + 32'(4 * i), 4'hF, 32'd0, 8'(140 + i), w);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_backpressure();
        int      idx;
        int      seen_before;
        int      n;
        logic    have_snap;
        logic    unstable;
        tl_d2h_t snap;
        tl_d2h_t cur;
        idx         = 0;
        have_snap   = 1'b0;
        unstable    = 1'b0;
        seen_before = rsp_seen;
        io.tl_d_i.d_ready = 1'b0;
        set_req(Get, 2'd2, BaseAddr, 4'hF, 32'd0, 8'd16);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (io.tl_d_o.d_valid) begin
                cur = io.tl_d_o;
                cur.a_ready = 1'b0;
                if (!have_snap) begin
                    snap      = cur;
                    have_snap = 1'b1;
                end else if (cur !== snap) begin
                    unstable = 1'b1;
                end
            end
            if (io.tl_d_o.a_ready && idx < 8) begin
                exp_q.push_back(model_req(Get, 2'd2, BaseAddr + 32'(4 * idx), 4'hF, 32'd0, 8'(16 + idx)));
                idx++;
            end
            @(posedge clock); #1;
            if (idx < 8) set_req(Get, 2'd2, BaseAddr + 32'(4 * idx), 4'hF, 32'd0, 8'(16 + idx));
        end
        tests_run++;
        if (idx != 4) begin
            tests_failed++;
            $display("[TB] FAIL bp_accepted: got %0d accepted, required 4", idx);
        end
        tests_run++;
        if (io.tl_d_o.a_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_a_ready: got a_ready=%0b, required 0", io.tl_d_o.a_ready);
        end
        tests_run++;
        if (!have_snap || unstable || rsp_seen != seen_before) begin
            tests_failed++;
            $display("[TB] FAIL bp_stable: got valid_seen=%0b unstable=%0b responses=%0d, required 1 0 0",
                     have_snap, unstable, rsp_seen - seen_before);
        end
        io.tl_d_i.d_ready = 1'b1;
        n = 0;
        while (idx < 8 && n < 60) begin
            @(negedge clock);
            if (io.tl_d_o.a_ready) begin
                exp_q.push_back(model_req(Get, 2'd2, BaseAddr + 32'(4 * idx), 4'hF, 32'd0, 8'(16 + idx)));
                idx++;
            end
            @(posedge clock); #1;
            if (idx < 8) set_req(Get, 2'd2, BaseAddr + 32'(4 * idx), 4'hF, 32'd0, 8'(16 + idx));
            n++;
        end
        io.tl_d_i.a_valid = 1'b0;
        tests_run++;
        if (idx != 8) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got %0d accepted, required 8", idx);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid();
        int w;
        int seen_before;
        send(PutFullData, 2'd2, 32'h1000_0024, 4'hF, 32'h5A5A_0F0F, 8'd30, w);
        wait_drain("pre_reset");
        io.tl_d_i.d_ready = 1'b0;
        send(Get, 2'd2, 32'h1000_0000, 4'hF, 32'd0, 8'd31, w);
        send(Get, 2'd2, 32'h1000_0004, 4'hF, 32'd0, 8'd32, w);
        send(Get, 2'd2, 32'h1000_0008, 4'hF, 32'd0, 8'd33, w);
        repeat (2) begin
            @(posedge clock); #1;
        end
        tests_run++;
        if (io.tl_d_o.d_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_pending: got d_valid=%0b before reset, required 1", io.tl_d_o.d_valid);
        end
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.a_ready !== 1'b0 || io.tl_d_o.d_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_in_reset: got a_ready=%0b d_valid=%0b, required 0 0",
                     io.tl_d_o.a_ready, io.tl_d_o.d_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (io.tl_d_o.d_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_after_reset: got d_valid=%0b, required 0", io.tl_d_o.d_valid);
        end
        io.tl_d_i.d_ready = 1'b1;
        seen_before = rsp_seen;
        repeat (5) @(negedge clock);
        tests_run++;
        if (rsp_seen != seen_before) begin
            tests_failed++;
            $display("[TB] FAIL mid_stale: got %0d stale responses, required 0", rsp_seen - seen_before);
        end
        @(posedge clock); #1;
        send(Get, 2'd2, 32'h1000_0024, 4'hF, 32'd0, 8'd34, w);
        wait_drain("post_reset");
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity();
        int w;
        send(PutFullData, 2'd2, 32'h1000_0030, 4'hF, 32'h0000_00FF, 8'd50, w);
        wait_drain("parity_put");
        dut.mem[12][0][0] = ~dut.mem[12][0][0];
        model[12] = 32'h0000_00FE;
        send(Get, 2'd2, 32'h1000_0030, 4'hF, 32'd0, 8'd51, w);
        exp_q[exp_q.size() - 1].error = 1'b1;
        wait_drain("parity_get");
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tlul_data_mem.md
# tlul_data_mem

Parametrised TL-UL device-side data memory: the next-generation DCCM/data RAM behind the crossbar, replacing the fixed 4 KiB DFFRAM-plus-adapter arrangement. Handles Get/PutFullData/PutPartialData directly with true per-byte write enables, protocol and address error checking, a configurable number of outstanding requests, and D-channel backpressure through an internal response FIFO. An optional per-byte parity store flags corrupted read data.

## Interface
- `Depth`, 1024: number of 32-bit words; power of two, minimum 16; `AW = $clog2(Depth)`.
- `Outstanding`, 4: response FIFO depth, minimum 2; at least 3 is required for one-request-per-cycle throughput.
- `BaseAddr`, 32'h1000_0000: region base; bits `[31:AW+2]` are checked.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `tl_d_i`  in  `tlul_pkg::tl_h2d_t`  A channel and `d_ready`.
- `tl_d_o`  out  `tlul_pkg::tl_d2h_t`  D channel and `a_ready`.

## Operation
- **A accept:** the request is accepted when `a_valid && a_ready`.
  - `a_ready = reset && (fifo_count + s1_valid) < Outstanding`.
- **Address and size:**
  - Word index is `a_address[AW+1:2]`.
  - Lane mask is 4'b0001 shifted by `addr[1:0]` for size 0, 4'b0011 shifted by `{addr[1],1'b0}` for size 1, and 4'b1111 for size 2.
- **Error conditions** (any one makes the request an error):
  - opcode not in {Get=4, PutFull=0, PutPartial=1};
  - `a_size > 2`;
  - size 1 with `addr[0]=1`;
  - size 2 with `addr[1:0]!=0`;
  - `a_address[31:AW+2] != BaseAddr[31:AW+2]`;
  - PutFull with `a_mask != lane`;
  - PutPartial with `a_mask` outside the lane or equal to 0.
- **Error requests:** the memory is not touched; the response has `d_error=1` and `d_data=0`.
- **Writes:**
  - Performed on the accept edge.
  - Byte `b` is written iff `a_mask[b]`; other bytes are unchanged.
- **Reads:**
  - The RAM is read on the accept edge; `Do` is valid in the next cycle (stage S1).
  - Get always returns the full word, regardless of mask.
- **S1 register:** holds `{opcode, size, source, error}` for one cycle, then pushes `{meta, data}` into the FIFO unconditionally. Space is guaranteed by the `a_ready` rule.
- **D channel:**
  - Driven from the FIFO head.
  - `d_opcode` = AccessAckData (1) for Get, AccessAck (0) for Put.
  - `d_size` and `d_source` are echoed from the request.
  - `d_param=0`, `d_sink=0`, `d_user=0`.
  - `d_data=0` on AccessAck.
- **Ordering:** responses are returned strictly in request order.
- **Reset values:** `d_valid=0`, `a_ready=0` while reset is low; `d_error=0`, `d_data=0`. FIFO and S1 are cleared. RAM contents are not reset.

## Timing
- **Latency:** request accepted at edge N gives `d_valid` high in cycle N+2, provided the FIFO was empty.
- **Throughput:** with `d_ready` held high and `Outstanding>=3`, one request per cycle is sustained indefinitely.
- **Backpressure:** while `d_valid && !d_ready`, all D fields stay stable. Acceptance stops once `fifo_count + s1_valid == Outstanding`.
- **FIFO pointers:** push and pop in the same cycle are allowed and leave the count unchanged. Pointers wrap modulo `Outstanding`.
- **Read-after-write, same word:**
  - A Get accepted the cycle after a Put returns the new data.
  - A same-cycle hazard cannot occur, because there is one request per cycle.
- **Reset mid-operation:** pending S1 and FIFO responses are dropped. Writes accepted before the reset edge are committed.

## Configuration
- **`DATA_MEM_PARITY_EN` defined:**
  - The RAM stores 4 extra even-parity bits, one per byte.
  - A write updates parity only for the bytes it writes.
  - A Get with any byte parity mismatch returns the stored data with `d_error=1`.
  - Protocol errors behave as without the macro.
- **Undefined:** no parity storage; `d_error` reflects protocol/address errors only.

## Structure
- **Package `tlul_data_mem_pkg`:**
  - `rsp_entry_t` {opcode, size, source, error, data};
  - `DataW=32` and `MaskW=4`;
  - function `lane_mask(size, addr[1:0])`.
- **Opcodes:** taken from `tlul_pkg`, not redefined.
- **Sub-module `tlul_data_mem_rsp_fifo`:** parametrised by `Outstanding` and entry type. It exposes `count`, `push`, `pop` and head data.
- **RAM:** an inferred byte-write array inside the top module.

## Test plan
- **Write then read:** PutFull addr 0x1000_0010, data 0xDEADBEEF, then Get same address → AccessAck with `d_error=0`, then AccessAckData 0xDEADBEEF; `d_valid` at N+2.
- **Partial write:** PutPartial size 0, addr 0x1000_0012, mask 4'b0100, data 0x00AA0000, over word 0x11223344 → Get returns 0x11AA3344.
- **Error cases:** Get addr 0x2000_0000, PutFull size 2 with mask 4'b0111, size 1 at addr[0]=1 → each returns `d_error=1`, `d_data=0`; the target word is unchanged.
- **Backpressure:** hold `d_ready=0` and drive 8 back-to-back Gets (`Outstanding=4`) → exactly 4 accepted, `a_ready=0`, D fields stable; release → 4 in-order responses, then the rest are accepted.
- **Reset mid-stream:** `reset` low for 1 cycle with 3 responses pending → `d_valid=0` next cycle and no stale responses afterwards; a prior write persists.
- **Parity (with `DATA_MEM_PARITY_EN`):** write 0x000000FF, backdoor-flip a bit of byte 0, then Get → data returned with `d_error=1`.
